alu_arbiter: RTL and testbench

- Shares a single 64-bit ALU (valid_i/op/a/b in, z/valid_o out) between NUM_REQ independent requesters.
- Uses round-robin arbitration.
- One operation is in flight at a time. The block registers the granted operands, issues them to the ALU, and waits for the ALU valid_o, so ALU latency may be 0..N cycles.
- It then returns the result to the originating requester over a valid/ready response handshake.
- Sits between the execute-stage requesters and the shared ALU instance.

---
 rtl/alu_arb_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 35 +++
 rtl/alu_arbiter.sv | 160 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter slice.
package alu_arb_pkg;

    // ALU opcode map (codes 9..15 are outside the defined set)
    typedef enum logic [3:0] {
        AND    = 4'd0,
        OR     = 4'd1,
        NOT    = 4'd2,
        ADD    = 4'd3,
        SUB    = 4'd4,
        INC    = 4'd5,
        SHL    = 4'd6,
        SHR    = 4'd7,
        POPCNT = 4'd8
    } alu_op_t;

    localparam logic [3:0] ALU_OP_MAX = 4'd8;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // True when the opcode belongs to the defined ALU operation set
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= ALU_OP_MAX);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority search: first requester at or above
// ptr, wrapping at NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    logic [IDX_W-1:0] cand_s;

    // Walk candidates from ptr upward with wrap; the first active one wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        cand_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!any && req[cand_s]) begin
                any          = 1'b1;
                gnt[cand_s]  = 1'b1;
                gnt_idx      = cand_s;
            end else begin
                any     = any;
                gnt_idx = gnt_idx;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters, one operation in flight.
// Optional macro ALU_ARB_ILLEGAL_OP_EN: opcodes 9..15 bypass the ALU and
// return resp_z=0 with resp_err=1; without it every opcode is issued and
// resp_err stays 0.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0][63:0] req_a,
    input  logic [NUM_REQ-1:0][63:0] req_b,
    input  logic [NUM_REQ-1:0][3:0]  req_op,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [63:0]              resp_z,
    output logic                     resp_err,
    output logic                     alu_valid_i,
    output logic [63:0]              alu_a,
    output logic [63:0]              alu_b,
    output logic [3:0]               alu_op,
    input  logic [63:0]              alu_z,
    input  logic                     alu_valid_o
);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               alu_valid_q, alu_valid_d;
    logic [63:0]        alu_a_q, alu_a_d;
    logic [63:0]        alu_b_q, alu_b_d;
    logic [3:0]         alu_op_q, alu_op_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [63:0]        resp_z_q, resp_z_d;
    logic               resp_err_q, resp_err_d;

    logic [NUM_REQ-1:0] gnt_s;
    logic [IDX_W-1:0]   gnt_idx_s;
    logic               any_s;
    logic               illegal_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .any     (any_s)
    );

`ifdef ALU_ARB_ILLEGAL_OP_EN
    assign illegal_s = !op_is_legal(req_op[gnt_idx_s]);
`else
    assign illegal_s = 1'b0;
`endif

    // Next-state and handshake decode for the IDLE/ISSUE/WAIT/RESP sequence
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        idx_d        = idx_q;
        alu_valid_d  = alu_valid_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        resp_valid_d = resp_valid_q;
        resp_z_d     = resp_z_q;
        resp_err_d   = resp_err_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                // Grant is only offered while out of reset
                req_ready = rst ? gnt_s : '0;
                if (any_s) begin
                    idx_d = gnt_idx_s;
                    if (illegal_s) begin
                        state_d      = RESP;
                        resp_valid_d = gnt_s;
                        resp_z_d     = 64'd0;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        alu_valid_d = 1'b1;
                        alu_a_d     = req_a[gnt_idx_s];
                        alu_b_d     = req_b[gnt_idx_s];
                        alu_op_d    = req_op[gnt_idx_s];
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE, WAIT: begin
                if (alu_valid_o) begin
                    state_d             = RESP;
                    alu_valid_d         = 1'b0;
                    resp_valid_d        = '0;
                    resp_valid_d[idx_q] = 1'b1;
                    resp_z_d            = alu_z;
                    resp_err_d          = 1'b0;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                // Only the owning requester's ready bit can retire the result
                if (resp_ready[idx_q]) begin
                    state_d      = IDLE;
                    resp_valid_d = '0;
                    rr_ptr_d     = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d      = IDLE;
                alu_valid_d  = 1'b0;
                resp_valid_d = '0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight operation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            idx_q        <= '0;
            alu_valid_q  <= 1'b0;
            alu_a_q      <= 64'd0;
            alu_b_q      <= 64'd0;
            alu_op_q     <= 4'd0;
            resp_valid_q <= '0;
            resp_z_q     <= 64'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            idx_q        <= idx_d;
            alu_valid_q  <= alu_valid_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            resp_valid_q <= resp_valid_d;
            resp_z_q     <= resp_z_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign alu_valid_i = alu_valid_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign resp_valid  = resp_valid_q;
    assign resp_z      = resp_z_q;
    assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed stimulus pushes expected
// responses; a negedge monitor pops and compares on each response handshake.
module tb_alu_arbiter;

    localparam int N = 4;

    typedef struct {
        int          idx;
        logic [63:0] z;
        logic        err;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid, req_ready, resp_valid, resp_ready;
    logic [N-1:0][63:0] req_a, req_b;
    logic [N-1:0][3:0] req_op;
    logic [63:0]       resp_z, alu_a, alu_b, alu_z;
    logic              resp_err, alu_valid_i, alu_valid_o;
    logic [3:0]        alu_op;

    int   alu_lat  = 0;
    int   alu_cnt  = 0;
    int   pass_cnt = 0;
    int   tot_cnt  = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_z      (resp_z),
        .resp_err    (resp_err),
        .alu_valid_i (alu_valid_i),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_z       (alu_z),
        .alu_valid_o (alu_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU behaviour
    function automatic logic [63:0] alu_f(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return ~a;
            4'd3:    return a + b;
            4'd4:    return a - b;
            4'd5:    return a + 64'd1;
            4'd6:    return a << b[5:0];
            4'd7:    return a >> b[5:0];
            4'd8:    return 64'($countones(a));
            default: return 64'd0;
        endcase
    endfunction

    // ALU model with programmable latency; z is garbage unless valid_o
    always @(posedge clk) begin
        if (!alu_valid_i) alu_cnt <= 0;
        else if (alu_cnt < alu_lat) alu_cnt <= alu_cnt + 1;
    end
    assign alu_valid_o = alu_valid_i && (alu_cnt >= alu_lat);
    assign alu_z       = alu_valid_o ? alu_f(alu_op, alu_a, alu_b) : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic push(input int idx, input logic [63:0] z, input logic err);
        exp_t e;
        e.idx = idx;
        e.z   = z;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every completed response handshake is checked against the queue
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                if (resp_valid[i] && resp_ready[i]) begin
                    if (exp_q.size() == 0) begin
                        chk("resp_unexpected", 64'(i), 64'hFFFF);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("resp_idx", 64'(i), 64'(mon_e.idx));
                        chk("resp_z", resp_z, mon_e.z);
                        chk("resp_err", 64'(resp_err), 64'(mon_e.err));
                    end
                end
            end
        end
    end

    initial begin
        int rr_order[5] = '{0, 1, 2, 3, 0};
        int k, cyc, last;
        logic [N-1:0] want;

        rst = 1'b0; req_valid = '0; resp_ready = '0;
        req_a = '0; req_b = '0; req_op = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready",   64'(req_ready),   64'd0);
        chk("rst_resp_valid",  64'(resp_valid),  64'd0);
        chk("rst_alu_valid_i", 64'(alu_valid_i), 64'd0);
        chk("rst_alu_a",       alu_a,            64'd0);
        chk("rst_alu_b",       alu_b,            64'd0);
        chk("rst_alu_op",      64'(alu_op),      64'd0);
        chk("rst_resp_z",      resp_z,           64'd0);
        chk("rst_resp_err",    64'(resp_err),    64'd0);
        rst = 1'b1;
        tick();

        // Round robin, all requesters valid, 0-cycle ALU
        req_a[0] = 64'd10;     req_b[0] = 64'd20;     req_op[0] = 4'd3;
        req_a[1] = 64'd100;    req_b[1] = 64'd1;      req_op[1] = 4'd4;
        req_a[2] = 64'hFF00;   req_b[2] = 64'h0FF0;   req_op[2] = 4'd0;
        req_a[3] = 64'hF0F0;   req_b[3] = 64'd0;      req_op[3] = 4'd8;
        push(0, 64'd30, 1'b0); push(1, 64'd99, 1'b0); push(2, 64'h0F00, 1'b0);
        push(3, 64'd8, 1'b0);  push(0, 64'd30, 1'b0);
        req_valid = '1; resp_ready = '1;
        k = 0; cyc = 0; last = 0;
        while (k < 5 && cyc < 40) begin
            @(negedge clk);
            if (req_ready != '0) begin
                want = '0;
                want[rr_order[k]] = 1'b1;
                chk("rr_grant", 64'(req_ready), 64'(want));
                if (k > 0) chk("rr_spacing", 64'(cyc - last), 64'd3);
                last = cyc;
                k++;
            end
            tick();
            cyc++;
            if (k == 5) req_valid = '0;
        end
        req_valid = '0;
        chk("rr_grants", 64'(k), 64'd5);
        drain(20);
        resp_ready = '0;

        // Single request on requester 2: 5 + 7 = 12
        req_a[2] = 64'd5; req_b[2] = 64'd7; req_op[2] = 4'd3;
        req_valid = 4'b0100;
        push(2, 64'd12, 1'b0);
        @(negedge clk);
        chk("single_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0; req_a[2] = '1;
        @(negedge clk);
        chk("single_alu_valid", 64'(alu_valid_i), 64'd1);
        chk("single_alu_a", alu_a, 64'd5);
        chk("single_alu_b", alu_b, 64'd7);
        chk("single_alu_op", 64'(alu_op), 64'd3);
        chk("single_no_resp_yet", 64'(resp_valid), 64'd0);
        tick();
        resp_ready = 4'b0100;
        @(negedge clk);
        chk("single_resp_valid", 64'(resp_valid), 64'h4);
        chk("single_resp_z", resp_z, 64'd12);
        chk("single_alu_idle", 64'(alu_valid_i), 64'd0);
        tick();
        drain(10);
        resp_ready = '0;

        // Slow ALU (4 extra cycles) on requester 0: 1 << 4 = 16
        alu_lat = 4;
        req_a[0] = 64'd1; req_b[0] = 64'd4; req_op[0] = 4'd6;
        req_valid = 4'b0001;
        push(0, 64'd16, 1'b0);
        @(negedge clk);
        chk("slow_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0; req_a[0] = 64'hDEAD; req_b[0] = 64'hBEEF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("slow_alu_valid", 64'(alu_valid_i), 64'd1);
            chk("slow_alu_a", alu_a, 64'd1);
            chk("slow_alu_b", alu_b, 64'd4);
            chk("slow_alu_op", 64'(alu_op), 64'd6);
            chk("slow_no_resp", 64'(resp_valid), 64'd0);
            tick();
        end
        resp_ready = 4'b0001;
        @(negedge clk);
        chk("slow_resp_valid", 64'(resp_valid), 64'h1);
        chk("slow_resp_z", resp_z, 64'd16);
        chk("slow_alu_idle", 64'(alu_valid_i), 64'd0);
        tick();
        drain(10);
        resp_ready = '0;
        alu_lat = 0;

        // Backpressure on requester 1: NOT of a pattern, others' ready ignored
        req_a[1] = 64'h0123_4567_89AB_CDEF; req_b[1] = 64'd0; req_op[1] = 4'd2;
        req_valid = 4'b0010;
        push(1, 64'hFEDC_BA98_7654_3210, 1'b0);
        @(negedge clk);
        chk("bp_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = 4'b1101; resp_ready = 4'b1101;
        tick();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_resp_valid", 64'(resp_valid), 64'h2);
            chk("bp_resp_z", resp_z, 64'hFEDC_BA98_7654_3210);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_alu_idle", 64'(alu_valid_i), 64'd0);
            tick();
        end
        resp_ready = 4'b0010; req_valid = '0;
        drain(10);
        resp_ready = '0;

        // Reset during WAIT on requester 3; the op is dropped
        alu_lat = 4;
        req_a[3] = 64'd1; req_b[3] = 64'd1; req_op[3] = 4'd3;
        req_valid = 4'b1000;
        @(negedge clk);
        chk("mid_ready", 64'(req_ready), 64'h8);
        tick();
        req_valid = '0;
        tick();
        #2;
        rst = 1'b0;
        req_valid = '1;
        req_a[0] = 64'd10; req_b[0] = 64'd20; req_op[0] = 4'd3;
        alu_lat = 0;
        #1;
        chk("mid_rst_alu_valid", 64'(alu_valid_i), 64'd0);
        chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_alu_a", alu_a, 64'd0);
        chk("mid_rst_alu_op", 64'(alu_op), 64'd0);
        chk("mid_rst_resp_z", resp_z, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_grant", 64'(req_ready), 64'h1);
        push(0, 64'd30, 1'b0);
        resp_ready = '1;
        tick();
        req_valid = '0;
        drain(20);
        resp_ready = '0;

`ifdef ALU_ARB_ILLEGAL_OP_EN
        // Illegal opcode 12 on requester 1: never issued, error response
        req_a[1] = 64'd7; req_op[1] = 4'd12;
        req_valid = 4'b0010;
        push(1, 64'd0, 1'b1);
        @(negedge clk);
        chk("ill_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0; resp_ready = 4'b0010;
        @(negedge clk);
        chk("ill_resp_valid", 64'(resp_valid), 64'h2);
        chk("ill_alu_valid", 64'(alu_valid_i), 64'd0);
        chk("ill_resp_z", resp_z, 64'd0);
        chk("ill_resp_err", 64'(resp_err), 64'd1);
        tick();
        drain(10);
        resp_ready = '0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
